// File: rtl/grid_param_ctrl_if.sv
// Update channels from the plate locator and the character segmenter into the
// grid parameter controller. Each channel is a valid/ready handshake with its payload.
interface grid_param_ctrl_if;
  logic        plate_valid;
  logic        plate_ready;
  logic        plate_found;
  logic [9:0]  plate_up;
  logic [9:0]  plate_down;
  logic [9:0]  plate_left;
  logic [9:0]  plate_right;
  logic        char_valid;
  logic        char_ready;
  logic [9:0]  char_up;
  logic [9:0]  char_down;
  logic [69:0] char_left_bus;
  logic [69:0] char_right_bus;

  modport master (
    output plate_valid, plate_found, plate_up, plate_down, plate_left, plate_right,
    output char_valid, char_up, char_down, char_left_bus, char_right_bus,
    input  plate_ready, char_ready
  );

  modport slave (
    input  plate_valid, plate_found, plate_up, plate_down, plate_left, plate_right,
    input  char_valid, char_up, char_down, char_left_bus, char_right_bus,
    output plate_ready, char_ready
  );
endinterface

// File: rtl/grid_param_ctrl.sv
// Overlay geometry controller: validates plate/char updates into shadow registers and
// commits them atomically at frame start. A track/coast/off FSM keeps the plate box
// alive for HOLD_FRAMES frames without a detection.
module grid_param_ctrl #(
  parameter int unsigned HOLD_FRAMES = 4,
  parameter int unsigned IMG_W       = 640,
  parameter int unsigned IMG_H       = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              per_frame_vsync,
  grid_param_ctrl_if.slave  bus,
  output logic [9:0]        plate_boarder_up,
  output logic [9:0]        plate_boarder_down,
  output logic [9:0]        plate_boarder_left,
  output logic [9:0]        plate_boarder_right,
  output logic              plate_exist_flag,
  output logic [9:0]        char_line_up,
  output logic [9:0]        char_line_down,
  output logic [69:0]       char_left_out,
  output logic [69:0]       char_right_out,
  output logic              commit_pulse,
  output logic [7:0]        reject_cnt
);
  localparam logic [10:0] ImgW    = 11'(IMG_W);
  localparam logic [10:0] ImgH    = 11'(IMG_H);
  localparam logic [3:0]  Hold    = 4'(HOLD_FRAMES);
  localparam logic [9:0]  RowPark = 10'h3FF;
  localparam logic [69:0] ColPark = {7{10'h3FF}};

  typedef enum logic [1:0] {StOff, StTrack, StCoast} state_e;

  state_e      state_q, state_d;
  logic [3:0]  miss_q, miss_d, miss_inc;
  logic        vsync_s, vsync_q0, vsync_q1, fs;
  logic        plate_pend_q, plate_pend_d, char_pend_q, char_pend_d;
  logic        plate_ok, char_ok, plate_acc, char_acc, plate_fail, char_fail;
  logic        sh_found;
  logic [9:0]  sh_up, sh_down, sh_left, sh_right;
  logic [9:0]  sh_cup, sh_cdown;
  logic [69:0] sh_cleft, sh_cright;
  logic [9:0]  box_up_d, box_down_d, box_left_d, box_right_d;
  logic        exist_d;
  logic [9:0]  cup_d, cdown_d;
  logic [69:0] cleft_d, cright_d;
  logic        changed;
  logic [8:0]  rej_sum;
  logic [7:0]  reject_d;

  // vsync passes one sampling flop, then the edge-detect pair
  assign fs = vsync_q0 && !vsync_q1;

  assign bus.plate_ready = !plate_pend_q;
  assign bus.char_ready  = !char_pend_q;

  // Validate incoming updates; a clear (found=0) is always acceptable
  always_comb begin
    plate_ok = !bus.plate_found ||
               ((bus.plate_up < bus.plate_down) && (bus.plate_left < bus.plate_right) &&
                ({1'b0, bus.plate_right} < ImgW) && ({1'b0, bus.plate_down} < ImgH));
    char_ok = bus.char_up < bus.char_down;
    for (int i = 0; i < 7; i++) begin
      if (!(bus.char_left_bus[10*i +: 10] < bus.char_right_bus[10*i +: 10])) char_ok = 1'b0;
    end
    for (int i = 0; i < 6; i++) begin
      if (!(bus.char_right_bus[10*i +: 10] < bus.char_left_bus[10*(i+1) +: 10])) char_ok = 1'b0;
    end
  end

  assign plate_acc  = bus.plate_valid && bus.plate_ready && plate_ok;
  assign plate_fail = bus.plate_valid && bus.plate_ready && !plate_ok;
  assign char_acc   = bus.char_valid && bus.char_ready && char_ok;
  assign char_fail  = bus.char_valid && bus.char_ready && !char_ok;

  // Pending flags clear at frame start; a transfer in that same cycle re-arms them
  always_comb begin
    plate_pend_d = plate_pend_q;
    char_pend_d  = char_pend_q;
    if (fs) begin
      plate_pend_d = 1'b0;
      char_pend_d  = 1'b0;
    end
    if (plate_acc) plate_pend_d = 1'b1;
    if (char_acc)  char_pend_d  = 1'b1;
    rej_sum  = {1'b0, reject_cnt} + 9'(plate_fail) + 9'(char_fail);
    reject_d = rej_sum[8] ? 8'hFF : rej_sum[7:0];
  end

  // Frame-start decision: next FSM state and next committed outputs
  always_comb begin
    state_d     = state_q;
    miss_d      = miss_q;
    miss_inc    = miss_q + 4'd1;
    box_up_d    = plate_boarder_up;
    box_down_d  = plate_boarder_down;
    box_left_d  = plate_boarder_left;
    box_right_d = plate_boarder_right;
    cup_d       = char_line_up;
    cdown_d     = char_line_down;
    cleft_d     = char_left_out;
    cright_d    = char_right_out;
    if (fs) begin
      if (plate_pend_q && !sh_found) begin
        state_d = StOff;
        miss_d  = 4'd0;
      end else if (plate_pend_q) begin
        state_d     = StTrack;
        miss_d      = 4'd0;
        box_up_d    = sh_up;
        box_down_d  = sh_down;
        box_left_d  = sh_left;
        box_right_d = sh_right;
      end else begin
        unique case (state_q)
          StOff: ;
          StTrack: begin
            // A one-frame hold budget is already spent by the first empty frame
            if (Hold <= 4'd1) begin
              state_d = StOff;
              miss_d  = 4'd0;
            end else begin
              state_d = StCoast;
              miss_d  = 4'd1;
            end
          end
          StCoast: begin
            if (miss_inc >= Hold) begin
              state_d = StOff;
              miss_d  = 4'd0;
            end else begin
              miss_d = miss_inc;
            end
          end
          default: begin
            state_d = StOff;
            miss_d  = 4'd0;
          end
        endcase
      end
      if (state_d == StOff) begin
        cup_d    = RowPark;
        cdown_d  = RowPark;
        cleft_d  = ColPark;
        cright_d = ColPark;
      end else if (char_pend_q) begin
        cup_d    = sh_cup;
        cdown_d  = sh_cdown;
        cleft_d  = sh_cleft;
        cright_d = sh_cright;
      end
    end
    exist_d = (state_d != StOff);
    changed = fs && ({box_up_d, box_down_d, box_left_d, box_right_d, exist_d,
                      cup_d, cdown_d, cleft_d, cright_d} !=
                     {plate_boarder_up, plate_boarder_down, plate_boarder_left,
                      plate_boarder_right, plate_exist_flag, char_line_up, char_line_down,
                      char_left_out, char_right_out});
  end

  // All state: sync/edge flops, shadows, pending flags, FSM and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_s             <= 1'b0;
      vsync_q0            <= 1'b0;
      vsync_q1            <= 1'b0;
      plate_pend_q        <= 1'b0;
      char_pend_q         <= 1'b0;
      sh_found            <= 1'b0;
      sh_up               <= '0;
      sh_down             <= '0;
      sh_left             <= '0;
      sh_right            <= '0;
      sh_cup              <= RowPark;
      sh_cdown            <= RowPark;
      sh_cleft            <= ColPark;
      sh_cright           <= ColPark;
      state_q             <= StOff;
      miss_q              <= 4'd0;
      plate_boarder_up    <= '0;
      plate_boarder_down  <= '0;
      plate_boarder_left  <= '0;
      plate_boarder_right <= '0;
      plate_exist_flag    <= 1'b0;
      char_line_up        <= RowPark;
      char_line_down      <= RowPark;
      char_left_out       <= ColPark;
      char_right_out      <= ColPark;
      commit_pulse        <= 1'b0;
      reject_cnt          <= 8'd0;
    end else begin
      vsync_s      <= per_frame_vsync;
      vsync_q0     <= vsync_s;
      vsync_q1     <= vsync_q0;
      plate_pend_q <= plate_pend_d;
      char_pend_q  <= char_pend_d;
      reject_cnt   <= reject_d;
      if (plate_acc) begin
        sh_found <= bus.plate_found;
        sh_up    <= bus.plate_up;
        sh_down  <= bus.plate_down;
        sh_left  <= bus.plate_left;
        sh_right <= bus.plate_right;
      end
      if (char_acc) begin
        sh_cup    <= bus.char_up;
        sh_cdown  <= bus.char_down;
        sh_cleft  <= bus.char_left_bus;
        sh_cright <= bus.char_right_bus;
      end
      state_q             <= state_d;
      miss_q              <= miss_d;
      plate_boarder_up    <= box_up_d;
      plate_boarder_down  <= box_down_d;
      plate_boarder_left  <= box_left_d;
      plate_boarder_right <= box_right_d;
      plate_exist_flag    <= exist_d;
      char_line_up        <= cup_d;
      char_line_down      <= cdown_d;
      char_left_out       <= cleft_d;
      char_right_out      <= cright_d;
      commit_pulse        <= changed;
    end
  end
endmodule
